// File: rtl/mod_addsub_pipe.sv
// Two-stage modular add/subtract pipeline, LANES x 24-bit, with 12-bit split or
// 24-bit field modes, per-lane operand delay lines and a sticky range flag.
module mod_addsub_pipe #(
    parameter int unsigned LANES = 2,
    parameter int unsigned DLY_A = 6,
    parameter int unsigned DLY_B = 7,
    parameter int unsigned KQ    = 3329,
    parameter int unsigned DQ    = 8380417
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [1:0]            mode,
    input  logic                  sel_a_dly,
    input  logic                  sel_b_dly,
    input  logic [24*LANES-1:0]   a,
    input  logic [24*LANES-1:0]   b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [24*LANES-1:0]   sum,
    output logic                  range_err
);

    localparam logic [12:0] KQ13 = 13'(KQ);
    localparam logic [24:0] DQ25 = 25'(DQ);

    logic en;
    logic xfer;

    logic [23:0] dla_q [LANES][DLY_A];
    logic [23:0] dla_d [LANES][DLY_A];
    logic [23:0] dlb_q [LANES][DLY_B];
    logic [23:0] dlb_d [LANES][DLY_B];
    logic [23:0] op_a  [LANES];
    logic [23:0] op_b  [LANES];

    logic        s1_valid_q, s1_valid_d;
    logic [1:0]  s1_mode_q,  s1_mode_d;
    logic [12:0] s1_hi_q [LANES];
    logic [12:0] s1_hi_d [LANES];
    logic [12:0] s1_lo_q [LANES];
    logic [12:0] s1_lo_d [LANES];
    logic [24:0] s1_w_q  [LANES];
    logic [24:0] s1_w_d  [LANES];

    logic                s2_valid_q, s2_valid_d;
    logic [24*LANES-1:0] s2_sum_q,   s2_sum_d;
    logic                range_err_q, range_err_d;
    logic                oor;

    // Nothing is accepted while reset is held, so in_ready is gated by rst.
    always_comb begin
        en       = rst & (~s2_valid_q | out_ready);
        in_ready = en;
        xfer     = in_valid & en;
    end

    always_comb begin
        dla_d = dla_q;
        dlb_d = dlb_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            op_a[l] = sel_a_dly ? dla_q[l][DLY_A-1] : a[24*l +: 24];
            op_b[l] = sel_b_dly ? dlb_q[l][DLY_B-1] : b[24*l +: 24];
            if (xfer) begin
                for (int unsigned k = 1; k < DLY_A; k++) dla_d[l][k] = dla_q[l][k-1];
                for (int unsigned k = 1; k < DLY_B; k++) dlb_d[l][k] = dlb_q[l][k-1];
                dla_d[l][0] = a[24*l +: 24];
                dlb_d[l][0] = b[24*l +: 24];
            end
        end
    end

    // Stage 1: raw sum/difference with carry/borrow kept in the extra MSB.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_hi_d    = s1_hi_q;
        s1_lo_d    = s1_lo_q;
        s1_w_d     = s1_w_q;
        oor        = 1'b0;
        if (en) s1_valid_d = in_valid;
        if (xfer) s1_mode_d = mode;
        for (int unsigned l = 0; l < LANES; l++) begin
            if (mode[1]) begin
                oor = oor | ({1'b0, op_a[l]} >= DQ25) | ({1'b0, op_b[l]} >= DQ25);
            end else begin
                oor = oor | ({1'b0, op_a[l][23:12]} >= KQ13) | ({1'b0, op_a[l][11:0]} >= KQ13)
                          | ({1'b0, op_b[l][23:12]} >= KQ13) | ({1'b0, op_b[l][11:0]} >= KQ13);
            end
            if (xfer) begin
                s1_hi_d[l] = {1'b0, op_a[l][23:12]} + {1'b0, op_b[l][23:12]};
                s1_lo_d[l] = mode[0] ? ({1'b0, op_a[l][11:0]} + {1'b0, op_b[l][11:0]})
                                     : ({1'b0, op_a[l][11:0]} - {1'b0, op_b[l][11:0]});
                s1_w_d[l]  = mode[0] ? ({1'b0, op_a[l]} - {1'b0, op_b[l]})
                                     : ({1'b0, op_a[l]} + {1'b0, op_b[l]});
            end
        end
        range_err_d = range_err_q | (xfer & oor);
    end

    // Stage 2: one conditional correction per field.
    always_comb begin
        logic [11:0] hi_c;
        logic [11:0] lo_c;
        logic [23:0] w_c;
        s2_valid_d = s2_valid_q;
        s2_sum_d   = s2_sum_q;
        if (en) s2_valid_d = s1_valid_q;
        for (int unsigned l = 0; l < LANES; l++) begin
            hi_c = (s1_hi_q[l] >= KQ13) ? 12'(s1_hi_q[l] - KQ13) : s1_hi_q[l][11:0];
            if (s1_mode_q[0]) begin
                lo_c = (s1_lo_q[l] >= KQ13) ? 12'(s1_lo_q[l] - KQ13) : s1_lo_q[l][11:0];
                w_c  = s1_w_q[l][24] ? 24'(s1_w_q[l] + DQ25) : s1_w_q[l][23:0];
            end else begin
                lo_c = s1_lo_q[l][12] ? 12'(s1_lo_q[l] + KQ13) : s1_lo_q[l][11:0];
                w_c  = (s1_w_q[l] >= DQ25) ? 24'(s1_w_q[l] - DQ25) : s1_w_q[l][23:0];
            end
            if (en && s1_valid_q) begin
                s2_sum_d[24*l +: 24] = s1_mode_q[1] ? w_c : {hi_c, lo_c};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned l = 0; l < LANES; l++) begin
                for (int unsigned k = 0; k < DLY_A; k++) dla_q[l][k] <= '0;
                for (int unsigned k = 0; k < DLY_B; k++) dlb_q[l][k] <= '0;
                s1_hi_q[l] <= '0;
                s1_lo_q[l] <= '0;
                s1_w_q[l]  <= '0;
            end
            s1_valid_q  <= 1'b0;
            s1_mode_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_sum_q    <= '0;
            range_err_q <= 1'b0;
        end else begin
            dla_q       <= dla_d;
            dlb_q       <= dlb_d;
            s1_hi_q     <= s1_hi_d;
            s1_lo_q     <= s1_lo_d;
            s1_w_q      <= s1_w_d;
            s1_valid_q  <= s1_valid_d;
            s1_mode_q   <= s1_mode_d;
            s2_valid_q  <= s2_valid_d;
            s2_sum_q    <= s2_sum_d;
            range_err_q <= range_err_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = s2_sum_q;
    assign range_err = range_err_q;

endmodule

// File: tb/tb_mod_addsub_pipe.sv
// Scoreboard bench for mod_addsub_pipe: constant vectors, random stream with a
// consumer stall, delay-line, sticky range flag and mid-stream reset sequences.
module tb_mod_addsub_pipe;

    localparam int DLY_A = 6;
    localparam int DLY_B = 7;
    localparam longint KQ = 3329;
    localparam longint DQ = 8380417;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  mode;
    logic        sel_a_dly;
    logic        sel_b_dly;
    logic [47:0] a;
    logic [47:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [47:0] sum;
    logic        range_err;

    always #5 clk = ~clk;

    mod_addsub_pipe #(
        .LANES(2), .DLY_A(DLY_A), .DLY_B(DLY_B), .KQ(3329), .DQ(8380417)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode), .sel_a_dly(sel_a_dly), .sel_b_dly(sel_b_dly),
        .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .range_err(range_err)
    );

    typedef struct {
        logic [1:0]  mode;
        logic [47:0] a;
        logic [47:0] b;
        logic [47:0] exp;
    } vec_t;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic [47:0] exp_q  [$];
    logic [47:0] hist_a [$];
    logic [47:0] hist_b [$];
    int          pop_cyc[$];
    bit          exp_range = 1'b0;
    bit          prev_stall = 1'b0;
    logic [47:0] prev_sum = '0;
    bit          cur_use_model = 1'b0;
    logic [47:0] cur_exp = '0;

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic longint add_m(input longint x, input longint y, input longint k);
        longint s = x + y;
        if (s >= k) s = s - k;
        return s;
    endfunction

    function automatic longint sub_m(input longint x, input longint y, input longint k);
        longint d = x - y;
        if (d < 0) d = d + k;
        return d;
    endfunction

    function automatic logic [23:0] lane_model(input logic [1:0] m, input logic [23:0] x, input logic [23:0] y);
        longint h, l;
        if (m[1]) begin
            if (m[0]) return 24'(sub_m(longint'(x), longint'(y), DQ));
            return 24'(add_m(longint'(x), longint'(y), DQ));
        end
        h = add_m(longint'(x[23:12]), longint'(y[23:12]), KQ);
        l = m[0] ? add_m(longint'(x[11:0]), longint'(y[11:0]), KQ)
                 : sub_m(longint'(x[11:0]), longint'(y[11:0]), KQ);
        return {12'(h), 12'(l)};
    endfunction

    function automatic bit lane_oor(input logic [1:0] m, input logic [23:0] x, input logic [23:0] y);
        if (m[1]) return (longint'(x) >= DQ) || (longint'(y) >= DQ);
        return (longint'(x[23:12]) >= KQ) || (longint'(x[11:0]) >= KQ) ||
               (longint'(y[23:12]) >= KQ) || (longint'(y[11:0]) >= KQ);
    endfunction

    // Monitor: all sampling on the falling edge, away from the active edge.
    always @(negedge clk) begin
        logic [47:0] ea, eb, e;
        bit o;
        cyc++;
        if (!rst) begin
            check("rst_out_valid", 48'(out_valid), 48'(0));
            check("rst_in_ready", 48'(in_ready), 48'(0));
            check("rst_range_err", 48'(range_err), 48'(0));
            check("rst_sum", sum, 48'(0));
            exp_q.delete();
            hist_a.delete();
            hist_b.delete();
            exp_range  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            check("range_err", 48'(range_err), 48'(exp_range));
            check("in_ready", 48'(in_ready), 48'(!out_valid || out_ready));
            if (prev_stall) begin
                check("hold_valid", 48'(out_valid), 48'(1));
                check("hold_sum", sum, prev_sum);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got %0h want none (t=%0t)", sum, $time);
                end else begin
                    check("sum", sum, exp_q.pop_front());
                end
                pop_cyc.push_back(cyc);
            end
            prev_stall = out_valid && !out_ready;
            prev_sum   = sum;
            if (in_valid && in_ready) begin
                ea = sel_a_dly ? ((hist_a.size() >= DLY_A) ? hist_a[hist_a.size()-DLY_A] : 48'(0)) : a;
                eb = sel_b_dly ? ((hist_b.size() >= DLY_B) ? hist_b[hist_b.size()-DLY_B] : 48'(0)) : b;
                o  = 1'b0;
                for (int l = 0; l < 2; l++) begin
                    e[24*l +: 24] = lane_model(mode, ea[24*l +: 24], eb[24*l +: 24]);
                    o = o | lane_oor(mode, ea[24*l +: 24], eb[24*l +: 24]);
                end
                exp_q.push_back(cur_use_model ? e : cur_exp);
                hist_a.push_back(a);
                hist_b.push_back(b);
                if (o) exp_range = 1'b1;
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that took the transfer.
    task automatic send(input logic [1:0] m, input bit sa, input bit sb,
                        input logic [47:0] av, input logic [47:0] bv,
                        input bit use_model, input logic [47:0] ex);
        bit ok = 1'b0;
        mode = m; sel_a_dly = sa; sel_b_dly = sb; a = av; b = bv;
        cur_use_model = use_model; cur_exp = ex;
        in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: got no in_ready want in_ready within 50 cycles");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    function automatic logic [47:0] rand_op(input logic [1:0] m);
        logic [47:0] v;
        for (int l = 0; l < 2; l++) begin
            if (m[1]) v[24*l +: 24] = 24'($urandom_range(0, 8380416));
            else      v[24*l +: 24] = {12'($urandom_range(0, 3328)), 12'($urandom_range(0, 3328))};
        end
        return v;
    endfunction

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", 48'(exp_q.size()), 48'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl [7];
        logic [1:0]  m;
        logic [47:0] ex;
        int          lat;

        tbl[0] = '{2'b00, {12'd1, 12'd1, 12'd100, 12'd3000}, {12'd3328, 12'd2, 12'd3300, 12'd500},
                   {12'd0, 12'd3328, 12'd71, 12'd2500}};
        tbl[1] = '{2'b00, {12'd3328, 12'd3328, 12'd0, 12'd5}, {12'd3328, 12'd0, 12'd0, 12'd10},
                   {12'd3327, 12'd3328, 12'd0, 12'd3324}};
        tbl[2] = '{2'b10, {24'd8380416, 24'd8380000}, {24'd0, 24'd1000}, {24'd8380416, 24'd583}};
        tbl[3] = '{2'b11, {24'd10, 24'd5}, {24'd10, 24'd10}, {24'd0, 24'd8380412}};
        tbl[4] = '{2'b10, {24'd1, 24'd0}, {24'd8380416, 24'd0}, {24'd0, 24'd0}};
        tbl[5] = '{2'b01, {12'd1, 12'd2, 12'd1000, 12'd3000}, {12'd3, 12'd4, 12'd2329, 12'd400},
                   {12'd4, 12'd6, 12'd0, 12'd71}};
        tbl[6] = '{2'b11, {24'd8380416, 24'd0}, {24'd1, 24'd8380416}, {24'd8380415, 24'd1}};

        rst = 1'b0; in_valid = 1'b0; mode = '0; sel_a_dly = 1'b0; sel_b_dly = 1'b0;
        a = '0; b = '0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        do_reset();

        foreach (tbl[i]) send(tbl[i].mode, 1'b0, 1'b0, tbl[i].a, tbl[i].b, 1'b0, tbl[i].exp);
        drain();

        // Ten back-to-back transfers with a three-cycle consumer stall in the middle.
        pop_cyc.delete();
        fork
            for (int n = 0; n < 10; n++) begin
                m = 2'($urandom_range(0, 3));
                send(m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_op(m), rand_op(m), 1'b1, '0);
            end
            begin
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();
        check("stream_count", 48'(pop_cyc.size()), 48'(10));
        if (pop_cyc.size() == 10) check("stream_span", 48'(pop_cyc[9] - pop_cyc[0]), 48'(12));

        do_reset();
        for (int n = 0; n < 12; n++) begin
            ex = (n >= DLY_B) ? {24'(n - DLY_B + 100), 24'(n - DLY_B)} : '0;
            send(2'b10, 1'b0, 1'b1, '0, {24'(n + 100), 24'(n)}, 1'b0, ex);
        end
        drain();

        send(2'b00, 1'b0, 1'b0, {24'd0, 12'd3329, 12'd0}, '0, 1'b0, '0);
        send(2'b10, 1'b0, 1'b0, {24'd0, 24'd1}, {24'd0, 24'd2}, 1'b0, {24'd0, 24'd3});
        repeat (3) @(negedge clk);
        check("range_sticky", 48'(range_err), 48'(1));
        drain();

        send(2'b10, 1'b0, 1'b0, {24'd4, 24'd1}, {24'd5, 24'd2}, 1'b1, '0);
        send(2'b11, 1'b0, 1'b0, {24'd9, 24'd9}, {24'd1, 24'd1}, 1'b1, '0);
        rst = 1'b0;
        #1;
        check("rst_flush_valid", 48'(out_valid), 48'(0));
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        send(2'b10, 1'b0, 1'b0, {24'd20, 24'd7}, {24'd30, 24'd8}, 1'b0, {24'd50, 24'd15});
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("restart_latency", 48'(lat), 48'(2));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
